sram_port_arbiter: RTL and testbench

Shares one single-port 256x32 SRAM macro (fakeram7_256x32: registered read data, one address shared by reads and writes, no reset) between two requesters. Each requester has a valid/ready request channel and a read-response channel. Arbitration is round-robin, one SRAM access per cycle. The arbiter drives the macro pins directly, so FIFOs, DMA engines and debug ports can share one macro without local address muxing.

---
 rtl/sram_port_arbiter_if.sv | 46 ++++
 rtl/sram_port_arbiter.sv | 107 ++++++++++
 tb/tb_sram_port_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Request/response and SRAM-pin bundle for sram_port_arbiter.
// slave = arbiter side, master = requester/macro side.
interface sram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic              mem_ce;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_ce, mem_we, mem_addr, mem_wd,
        input  mem_rd
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_ce, mem_we, mem_addr, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin two-requester arbiter driving a single-port SRAM macro directly.
// Optional grant/conflict counters are enabled with SRAM_ARB_STATS_EN.
module sram_port_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clock,
    input  logic                resetn,
    sram_port_arbiter_if.slave  bus
`ifdef SRAM_ARB_STATS_EN
    ,
    input  logic                stats_clr,
    output logic [15:0]         gnt0_cnt,
    output logic [15:0]         gnt1_cnt,
    output logic [15:0]         conflict_cnt
`endif
);

    logic              gnt0, gnt1, both;
    logic              rr_ptr_q, rr_ptr_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_id_q, s1_id_d;
    logic              rsp0_valid_q, rsp1_valid_q;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp1_rdata_q;

    always_comb begin
        both = bus.req0_valid & bus.req1_valid;
        gnt0 = bus.req0_valid & (~bus.req1_valid | ~rr_ptr_q);
        gnt1 = bus.req1_valid & (~bus.req0_valid | rr_ptr_q);
        // After a conflict the pointer moves to the loser.
        rr_ptr_d   = both ? gnt0 : rr_ptr_q;
        s1_valid_d = (gnt0 & ~bus.req0_we) | (gnt1 & ~bus.req1_we);
        s1_id_d    = gnt1;
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    // Macro pins are forced idle while reset is asserted.
    always_comb begin
        bus.mem_ce   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_wd   = '0;
        if (resetn && gnt0) begin
            bus.mem_ce   = 1'b1;
            bus.mem_we   = bus.req0_we;
            bus.mem_addr = bus.req0_addr;
            bus.mem_wd   = bus.req0_we ? bus.req0_wdata : '0;
        end else if (resetn && gnt1) begin
            bus.mem_ce   = 1'b1;
            bus.mem_we   = bus.req1_we;
            bus.mem_addr = bus.req1_addr;
            bus.mem_wd   = bus.req1_we ? bus.req1_wdata : '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_q     <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_id_q      <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            rsp0_valid_q <= s1_valid_q & ~s1_id_q;
            rsp1_valid_q <= s1_valid_q & s1_id_q;
            if (s1_valid_q && !s1_id_q) rsp0_rdata_q <= bus.mem_rd;
            if (s1_valid_q && s1_id_q)  rsp1_rdata_q <= bus.mem_rd;
        end
    end

    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_rdata = rsp0_rdata_q;
    assign bus.rsp1_rdata = rsp1_rdata_q;

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] gnt0_cnt_q, gnt1_cnt_q, conflict_cnt_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            gnt0_cnt_q     <= '0;
            gnt1_cnt_q     <= '0;
            conflict_cnt_q <= '0;
        end else if (stats_clr) begin
            gnt0_cnt_q     <= '0;
            gnt1_cnt_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (gnt0 && gnt0_cnt_q != 16'hFFFF)         gnt0_cnt_q     <= gnt0_cnt_q + 16'd1;
            if (gnt1 && gnt1_cnt_q != 16'hFFFF)         gnt1_cnt_q     <= gnt1_cnt_q + 16'd1;
            if (both && conflict_cnt_q != 16'hFFFF)     conflict_cnt_q <= conflict_cnt_q + 16'd1;
        end
    end

    assign gnt0_cnt     = gnt0_cnt_q;
    assign gnt1_cnt     = gnt1_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed vector bench for sram_port_arbiter with a behavioural 256x32 SRAM.
module tb_sram_port_arbiter;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    sram_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

`ifdef SRAM_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] gnt0_cnt, gnt1_cnt, conflict_cnt;
`endif

    sram_port_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .bus          (bus.slave)
`ifdef SRAM_ARB_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .gnt0_cnt     (gnt0_cnt),
        .gnt1_cnt     (gnt1_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    // Macro model: registered read, shared address, no reset.
    logic [31:0] ram [256];
    always @(posedge clock) begin
        if (bus.mem_ce) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wd;
            else            bus.mem_rd <= ram[bus.mem_addr];
        end
    end

    typedef struct {
        logic        v0, we0; logic [7:0] a0; logic [31:0] d0;
        logic        v1, we1; logic [7:0] a1; logic [31:0] d1;
        logic [1:0]  rdy;
        logic        ce, we;  logic [7:0] ma; logic [31:0] md;
        logic        rv0, rv1; logic [31:0] rd0, rd1;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic we0, input logic [7:0] a0,
                         input logic [31:0] d0, input logic v1, input logic we1,
                         input logic [7:0] a1, input logic [31:0] d1);
        bus.req0_valid = v0; bus.req0_we = we0; bus.req0_addr = a0; bus.req0_wdata = d0;
        bus.req1_valid = v1; bus.req1_we = we1; bus.req1_addr = a1; bus.req1_wdata = d1;
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ready"}, {126'd0, bus.req0_ready, bus.req1_ready}, 128'd0);
        check({name, "_mem"}, {86'd0, bus.mem_ce, bus.mem_we, bus.mem_addr, bus.mem_wd}, 128'd0);
        check({name, "_rsp"}, {62'd0, bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata,
                               bus.rsp1_rdata}, 128'd0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Reference stream: fields are inputs, {ready0,ready1}, mem pins, responses.
        vecs.push_back('{1,1,8'h10,32'hDEADBEEF, 0,0,0,0, 2'b10, 1,1,8'h10,32'hDEADBEEF, 0,0,0,0});
        vecs.push_back('{1,0,8'h10,0, 0,0,0,0, 2'b10, 1,0,8'h10,0, 0,0,0,0});
        vecs.push_back('{0,0,0,0, 0,0,0,0, 2'b00, 0,0,0,0, 0,0,0,0});
        vecs.push_back('{0,0,0,0, 0,0,0,0, 2'b00, 0,0,0,0, 1,0,32'hDEADBEEF,0});
        vecs.push_back('{0,0,0,0, 1,1,8'hFF,32'h5, 2'b01, 1,1,8'hFF,32'h5, 0,0,32'hDEADBEEF,0});
        vecs.push_back('{1,0,8'hFF,0, 0,0,0,0, 2'b10, 1,0,8'hFF,0, 0,0,32'hDEADBEEF,0});
        vecs.push_back('{0,0,0,0, 0,0,0,0, 2'b00, 0,0,0,0, 0,0,32'hDEADBEEF,0});
        vecs.push_back('{0,0,0,0, 0,0,0,0, 2'b00, 0,0,0,0, 1,0,32'h5,0});
        for (int i = 0; i < 4; i++) begin
            vecs.push_back('{1,1,8'(i),32'hA0 + 32'(i), 0,0,0,0, 2'b10,
                             1,1,8'(i),32'hA0 + 32'(i), 0,0,32'h5,0});
        end
        for (int i = 0; i < 4; i++) begin
            vecs.push_back('{1,0,8'(i),0, 0,0,0,0, 2'b10, 1,0,8'(i),0,
                             (i >= 2), 0, (i >= 2) ? 32'hA0 + 32'(i - 2) : 32'h5, 0});
        end
        vecs.push_back('{0,0,0,0, 0,0,0,0, 2'b00, 0,0,0,0, 1,0,32'hA2,0});
        vecs.push_back('{0,0,0,0, 0,0,0,0, 2'b00, 0,0,0,0, 1,0,32'hA3,0});
        vecs.push_back('{1,0,8'h0,0, 1,0,8'h1,0, 2'b10, 1,0,8'h0,0, 0,0,32'hA3,0});
        vecs.push_back('{1,0,8'h0,0, 1,0,8'h1,0, 2'b01, 1,0,8'h1,0, 0,0,32'hA3,0});
        vecs.push_back('{1,0,8'h0,0, 1,0,8'h1,0, 2'b10, 1,0,8'h0,0, 1,0,32'hA0,0});
        vecs.push_back('{1,0,8'h0,0, 1,0,8'h1,0, 2'b01, 1,0,8'h1,0, 0,1,32'hA0,32'hA1});
        vecs.push_back('{1,0,8'h0,0, 1,0,8'h1,0, 2'b10, 1,0,8'h0,0, 1,0,32'hA0,32'hA1});
        vecs.push_back('{1,0,8'h0,0, 1,0,8'h1,0, 2'b01, 1,0,8'h1,0, 0,1,32'hA0,32'hA1});
        vecs.push_back('{0,0,0,0, 0,0,0,0, 2'b00, 0,0,0,0, 1,0,32'hA0,32'hA1});
        vecs.push_back('{0,0,0,0, 0,0,0,0, 2'b00, 0,0,0,0, 0,1,32'hA0,32'hA1});
        vecs.push_back('{0,0,0,0, 0,0,0,0, 2'b00, 0,0,0,0, 0,0,32'hA0,32'hA1});

        // Reset state
        repeat (2) @(negedge clock);
        #1 check_idle_outputs("reset");
        @(negedge clock);
        resetn = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clock);
            drive(vecs[k].v0, vecs[k].we0, vecs[k].a0, vecs[k].d0,
                  vecs[k].v1, vecs[k].we1, vecs[k].a1, vecs[k].d1);
            #1;
            check($sformatf("v%0d_ready", k), {126'd0, bus.req0_ready, bus.req1_ready},
                  {126'd0, vecs[k].rdy});
            check($sformatf("v%0d_mem", k),
                  {86'd0, bus.mem_ce, bus.mem_we, bus.mem_addr, bus.mem_wd},
                  {86'd0, vecs[k].ce, vecs[k].we, vecs[k].ma, vecs[k].md});
            check($sformatf("v%0d_rsp", k),
                  {62'd0, bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata, bus.rsp1_rdata},
                  {62'd0, vecs[k].rv0, vecs[k].rv1, vecs[k].rd0, vecs[k].rd1});
        end

`ifdef SRAM_ARB_STATS_EN
        check("stats_after_table", {80'd0, gnt0_cnt, gnt1_cnt, conflict_cnt},
              {80'd0, 16'd14, 16'd4, 16'd6});
        // Clear coincides with a grant; clear must win.
        @(negedge clock);
        drive(1, 0, 8'h0, 0, 0, 0, 0, 0);
        stats_clr = 1'b1;
        @(negedge clock);
        stats_clr = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("stats_clr_wins", {80'd0, gnt0_cnt, gnt1_cnt, conflict_cnt}, 128'd0);
        drive(1, 0, 8'h1, 0, 0, 0, 0, 0);
        repeat (70000) @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("stats_saturate", {80'd0, gnt0_cnt, gnt1_cnt, conflict_cnt},
                 {80'd0, 16'hFFFF, 16'd0, 16'd0});
        @(negedge clock);
        stats_clr = 1'b1;
        @(negedge clock);
        stats_clr = 1'b0;
        #1 check("stats_clr", {80'd0, gnt0_cnt, gnt1_cnt, conflict_cnt}, 128'd0);
        repeat (3) @(negedge clock);
`endif

        // Read accepted, then reset mid-flight: the response must be dropped.
        @(negedge clock);
        drive(1, 0, 8'h2, 0, 0, 0, 0, 0);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b0;
        #1 check_idle_outputs("midreset_a");
        @(negedge clock);
        #1 check_idle_outputs("midreset_b");
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1 check($sformatf("no_rsp_after_reset%0d", i),
                     {126'd0, bus.rsp0_valid, bus.rsp1_valid}, 128'd0);
        end

        // Normal operation resumes and SRAM contents survived the reset.
        @(negedge clock);
        drive(1, 0, 8'h3, 0, 1, 0, 8'h0, 0);
        #1 check("resume_ready", {126'd0, bus.req0_ready, bus.req1_ready}, 128'd2);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("resume_ready_b", {126'd0, bus.req0_ready, bus.req1_ready}, 128'd0);
        @(negedge clock);
        #1 check("resume_rsp", {95'd0, bus.rsp0_valid, bus.rsp0_rdata}, {95'd0, 1'b1, 32'hA3});
        @(negedge clock);
        #1 check("resume_rsp_pulse", {127'd0, bus.rsp0_valid}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
